// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: time-multiplexed driver for an N-digit common-anode
// 7-segment display (active-low anodes, segments and decimal point).
// Each digit holds a 4-bit code. A prescaler sets how long each digit is lit.
// Loads are double-buffered and committed only at the frame wrap, so a frame
// never shows a half-updated value.
//
// Optional feature macro: SSEG_HEX_EN
//   defined   -> codes 10..15 render as A b C d E F
//   undefined -> codes 10..15 render dark (seg = 7'h7F); AN and DP still act
//
// Ports:
//   clk        in  1             system clock, rising edge
//   reset      in  1             synchronous, active-high reset
//   load       in  1             strobe: capture digits_in/blank_in/dp_in
//   digits_in  in  4*NUM_DIGITS  digit i code in [4i+3:4i], digit 0 rightmost
//   blank_in   in  NUM_DIGITS    1 = digit i dark
//   dp_in      in  NUM_DIGITS    1 = decimal point of digit i lit
//   frame_done out 1             one-cycle pulse after the scan wraps
//   AN         out NUM_DIGITS    anode enables, active low, one-hot-low
//   seg        out 7             {g,f,e,d,c,b,a}, active low
//   DP         out 1             decimal point, active low
module sseg_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              seg,
  output logic                    DP
);

  localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CODE_W = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [CODE_W-1:0]     disp_code;
  logic [NUM_DIGITS-1:0] disp_blank;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [CODE_W-1:0]     pend_code;
  logic [NUM_DIGITS-1:0] pend_blank;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pend_valid;

  logic                  tick_c;
  logic                  wrap_c;
  logic [3:0]            code_c;
  logic                  blank_c;
  logic                  dp_c;
  logic [NUM_DIGITS-1:0] an_c;

  // Code to active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
`ifdef SSEG_HEX_EN
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
`endif
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign tick_c = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign wrap_c = tick_c && (idx == IDX_W'(NUM_DIGITS - 1));

  // Select the digit currently being scanned from the display buffer.
  always_comb begin
    code_c  = 4'h0;
    blank_c = 1'b1;
    dp_c    = 1'b0;
    an_c    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        code_c  = disp_code[4*i +: 4];
        blank_c = disp_blank[i];
        dp_c    = disp_dp[i];
        an_c[i] = 1'b0;
      end
    end
  end

  // Prescaler, scan index, double buffer and registered pin outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      disp_code  <= '0;
      disp_blank <= '1;
      disp_dp    <= '0;
      pend_code  <= '0;
      pend_blank <= '1;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      frame_done <= 1'b0;
      AN         <= '1;
      seg        <= 7'h7F;
      DP         <= 1'b1;
    end else begin
      cnt <= tick_c ? '0 : cnt + CNT_W'(1);
      if (tick_c) begin
        idx <= wrap_c ? '0 : idx + IDX_W'(1);
      end

      // A load on the wrap cycle goes straight to the display; otherwise it
      // waits in pending (last load wins) until the next wrap.
      if (load && wrap_c) begin
        disp_code  <= digits_in;
        disp_blank <= blank_in;
        disp_dp    <= dp_in;
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_code  <= digits_in;
        pend_blank <= blank_in;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end else if (wrap_c && pend_valid) begin
        disp_code  <= pend_code;
        disp_blank <= pend_blank;
        disp_dp    <= pend_dp;
        pend_valid <= 1'b0;
      end

      frame_done <= wrap_c;

      if (blank_c) begin
        AN  <= '1;
        seg <= 7'h7F;
        DP  <= 1'b1;
      end else begin
        AN  <= an_c;
        seg <= decode(code_c);
        DP  <= ~dp_c;
      end
    end
  end

endmodule
